spi_frame_master: RTL

- System-clock-domain SPI master that sequences one 32-bit frame per request against the SPI slave datapath.
- Frame layout: 24-bit payload, MSB first, then an 8-bit CRC.
- Generates `csn` and `sck`, shifts the payload and the CRC out on `mosi`, and captures 32 bits from `miso`.
- Checks the received CRC and reports the received payload plus a CRC-error flag to the host logic.

---
 rtl/spi_frame_master_if.sv | 27 ++
 rtl/spi_frame_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master_if.sv
// Host handshake and SPI pin bundle for spi_frame_master.
// master modport: the frame master itself; slave modport: the surrounding host/slave logic.
interface spi_frame_master_if;
    localparam int unsigned DATA_W = 24;

    logic              start;
    logic              abort;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              crc_err;
    logic              sck;
    logic              csn;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, abort, tx_data, miso,
        output busy, done, rx_data, crc_err, sck, csn, mosi
    );

    modport slave (
        output start, abort, tx_data, miso,
        input  busy, done, rx_data, crc_err, sck, csn, mosi
    );
endinterface

// File: rtl/spi_frame_master.sv
// SPI frame master: one 32-bit frame (24-bit payload MSB first + CRC-8) per start.
// Optional macro SPI_ERR_CNT_EN adds a saturating CRC-error counter output err_cnt.
module spi_frame_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [7:0]  CRC_POLY = 8'h1D,
    parameter logic [7:0]  CRC_INIT = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_frame_master_if.master     bus
`ifdef SPI_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned BIT_W        = 6;
    localparam int unsigned PAYLOAD_BITS = 24;
    localparam int unsigned FRAME_BITS   = 32;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [22:0]        tx_sr_q, tx_sr_d;
    logic [7:0]         crc_tx_q, crc_tx_d;
    logic [7:0]         crc_rx_q, crc_rx_d;
    logic [31:0]        rx_sr_q, rx_sr_d;
    logic               sck_q, sck_d;
    logic               csn_q, csn_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [23:0]        rx_data_q, rx_data_d;
    logic               crc_err_q, crc_err_d;
`ifdef SPI_ERR_CNT_EN
    logic [7:0]         err_cnt_q, err_cnt_d;
`endif

    // One serial CRC-8 step, MSB-first, no reflection.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        crc_tx_d  = crc_tx_q;
        crc_rx_d  = crc_rx_q;
        rx_sr_d   = rx_sr_q;
        sck_d     = sck_q;
        csn_d     = csn_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        crc_err_d = crc_err_q;
`ifdef SPI_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Bit 23 is presented right away, so the tx CRC absorbs it at load time.
                    state_d  = SETUP;
                    cnt_d    = '0;
                    bit_d    = '0;
                    tx_sr_d  = bus.tx_data[22:0];
                    mosi_d   = bus.tx_data[23];
                    crc_tx_d = crc_step(CRC_INIT, bus.tx_data[23]);
                    crc_rx_d = CRC_INIT;
                    csn_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        // Falling edge: capture miso.
                        sck_d   = 1'b0;
                        rx_sr_d = {rx_sr_q[30:0], bus.miso};
                        if (bit_q < BIT_W'(PAYLOAD_BITS)) begin
                            crc_rx_d = crc_step(crc_rx_q, bus.miso);
                        end
                        bit_d = bit_q + BIT_W'(1);
                    end else if (bit_q == BIT_W'(FRAME_BITS)) begin
                        // Low half of the last period is complete.
                        state_d = HOLD;
                    end else begin
                        // Rising edge 1..31: present the next payload or CRC bit.
                        sck_d = 1'b1;
                        if (bit_q < BIT_W'(PAYLOAD_BITS)) begin
                            mosi_d   = tx_sr_q[22];
                            tx_sr_d  = {tx_sr_q[21:0], 1'b0};
                            crc_tx_d = crc_step(crc_tx_q, tx_sr_q[22]);
                        end else begin
                            mosi_d   = crc_tx_q[7];
                            crc_tx_d = {crc_tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    state_d   = GAP;
                    csn_d     = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q[31:8];
                    crc_err_d = (rx_sr_q[7:0] != crc_rx_q);
`ifdef SPI_ERR_CNT_EN
                    if ((rx_sr_q[7:0] != crc_rx_q) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over any in-frame progress; completion results are discarded.
        if (bus.abort && (state_q == SETUP || state_q == SHIFT || state_q == HOLD)) begin
            state_d   = GAP;
            cnt_d     = '0;
            bit_d     = '0;
            sck_d     = 1'b0;
            csn_d     = 1'b1;
            mosi_d    = 1'b0;
            done_d    = 1'b0;
            rx_data_d = rx_data_q;
            crc_err_d = crc_err_q;
`ifdef SPI_ERR_CNT_EN
            err_cnt_d = err_cnt_q;
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            crc_tx_q  <= '0;
            crc_rx_q  <= '0;
            rx_sr_q   <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            crc_err_q <= 1'b0;
`ifdef SPI_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            crc_tx_q  <= crc_tx_d;
            crc_rx_q  <= crc_rx_d;
            rx_sr_q   <= rx_sr_d;
            sck_q     <= sck_d;
            csn_q     <= csn_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            crc_err_q <= crc_err_d;
`ifdef SPI_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign bus.sck     = sck_q;
    assign bus.csn     = csn_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.crc_err = crc_err_q;
`ifdef SPI_ERR_CNT_EN
    assign err_cnt     = err_cnt_q;
`endif
endmodule
